alu_regfile_pipe: RTL and testbench

Parametrised successor to the single-cycle register-file/ALU datapath: an NREGS×XLEN register file feeding a pipelined ALU whose result writes back into the register file. Adds immediate operands, a two-stage pipeline with EX→issue forwarding, a pipeline hold, a zero flag and a debug read port. Sits as the execute/writeback core under the future decode/control block.

---
 rtl/alu_regfile_pipe.sv | 124 ++++++++++++
 tb/tb_alu_regfile_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_pipe.sv
// Register file feeding a two-stage pipelined ALU with EX->issue forwarding,
// pipeline hold, zero flag and a combinational debug read port.
module alu_regfile_pipe #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter bit X0_ZERO = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            hold,
  input  logic [AW-1:0]   rr1,
  input  logic [AW-1:0]   rr2,
  input  logic [AW-1:0]   wr,
  input  logic            rw,
  input  logic [3:0]      ctl,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  output logic            res_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [AW-1:0]   res_wr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_NOR  = 4'b1100,
    OP_SRA  = 4'b1101
  } alu_op_e;

  logic [XLEN-1:0] regs [NREGS];

  logic            ex_valid;
  logic            ex_rw;
  logic [AW-1:0]   ex_wr;
  logic [3:0]      ex_ctl;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;

  logic [XLEN-1:0] alu_out;
  logic [SW-1:0]   shamt;
  logic            ex_writes;

  logic            fwd1, fwd2;
  logic [XLEN-1:0] rf1, rf2;
  logic [XLEN-1:0] op1, op2;

  // Register 0 is hard-wired to zero when X0_ZERO, both for reads and forwarding.
  assign rf1 = (X0_ZERO && rr1 == '0) ? '0 : regs[rr1];
  assign rf2 = (X0_ZERO && rr2 == '0) ? '0 : regs[rr2];
  assign dbg_data = (X0_ZERO && dbg_addr == '0) ? '0 : regs[dbg_addr];

  assign ex_writes = ex_valid && ex_rw && !(X0_ZERO && ex_wr == '0);
  assign fwd1 = ex_writes && (ex_wr == rr1);
  assign fwd2 = ex_writes && (ex_wr == rr2);

  assign op1 = fwd1 ? alu_out : rf1;
  assign op2 = use_imm ? imm : (fwd2 ? alu_out : rf2);

  assign shamt = ex_op2[SW-1:0];

  always_comb begin
    alu_out = '0;
    case (ex_ctl)
      OP_AND:  alu_out = ex_op1 & ex_op2;
      OP_OR:   alu_out = ex_op1 | ex_op2;
      OP_ADD:  alu_out = ex_op1 + ex_op2;
      OP_XOR:  alu_out = ex_op1 ^ ex_op2;
      OP_SLL:  alu_out = ex_op1 << shamt;
      OP_SRL:  alu_out = ex_op1 >> shamt;
      OP_SUB:  alu_out = ex_op1 - ex_op2;
      OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(ex_op1) < $signed(ex_op2))};
      OP_SLTU: alu_out = {{(XLEN-1){1'b0}}, (ex_op1 < ex_op2)};
      OP_NOR:  alu_out = ~(ex_op1 | ex_op2);
      OP_SRA:  alu_out = $unsigned($signed(ex_op1) >>> shamt);
      default: alu_out = '0;
    endcase
  end

  // WB result fields only load on real ops, so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      ex_valid  <= 1'b0;
      ex_rw     <= 1'b0;
      ex_wr     <= '0;
      ex_ctl    <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      res_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      res_wr    <= '0;
    end else if (!hold) begin
      ex_valid <= op_valid;
      ex_rw    <= rw;
      ex_wr    <= wr;
      ex_ctl   <= ctl;
      ex_op1   <= op1;
      ex_op2   <= op2;
      if (ex_writes) regs[ex_wr] <= alu_out;
      res_valid <= ex_valid;
      if (ex_valid) begin
        result <= alu_out;
        zero   <= (alu_out == '0);
        res_wr <= ex_wr;
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed-vector bench for alu_regfile_pipe (XLEN=32, NREGS=32, X0_ZERO=1).
module tb_alu_regfile_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        hold;
  logic [4:0]  rr1, rr2, wr;
  logic        rw;
  logic [3:0]  ctl;
  logic        use_imm;
  logic [31:0] imm;
  logic        res_valid;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  res_wr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_XOR = 4'b0011, C_SLL = 4'b0100, C_SRL = 4'b0101,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_SLTU = 4'b1000,
                         C_NOR = 4'b1100, C_SRA = 4'b1101, C_BAD = 4'b1111;

  alu_regfile_pipe #(.XLEN(32), .NREGS(32), .X0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .hold(hold),
    .rr1(rr1), .rr2(rr2), .wr(wr), .rw(rw), .ctl(ctl),
    .use_imm(use_imm), .imm(imm),
    .res_valid(res_valid), .result(result), .zero(zero), .res_wr(res_wr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic wen, input logic ui,
                        input logic [31:0] im);
    op_valid = 1'b1; ctl = c; rr1 = a; rr2 = b; wr = d; rw = wen;
    use_imm = ui; imm = im;
  endtask

  task automatic issue(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic wen, input logic ui,
                       input logic [31:0] im);
    set_op(c, a, b, d, wen, ui, im);
    tick();
  endtask

  task automatic idle();
    op_valid = 1'b0; rw = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(C_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5);
    tick();
    tick();
    rst = 1'b0; op_valid = 1'b0; rw = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_res_valid got %0b want 0", res_valid); end
    n_checks++;
    if (result !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_result got %h want 0", result); end
    n_checks++;
    if (zero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_zero got %0b want 0", zero); end
    n_checks++;
    if (res_wr !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_res_wr got %0d want 0", res_wr); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      n_checks++;
      if (dbg_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_dbg[%0d] got %h want 0", i, dbg_data); end
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_ghost got %0b want 0", res_valid); end
  endtask

  task automatic test_load_add();
    issue(C_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5);
    issue(C_ADD, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'd7);
    n_checks++;
    if (res_valid !== 1'b1 || result !== 32'd5 || res_wr !== 5'd1) begin
      n_fail++; $display("[TB] FAIL load1 got v=%0b r=%h wr=%0d want v=1 r=5 wr=1", res_valid, result, res_wr);
    end
    idle();
    n_checks++;
    if (res_valid !== 1'b1 || result !== 32'd7 || res_wr !== 5'd2) begin
      n_fail++; $display("[TB] FAIL load2 got v=%0b r=%h wr=%0d want v=1 r=7 wr=2", res_valid, result, res_wr);
    end
    idle();
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bubble_valid got %0b want 0", res_valid); end
    idle();
    issue(C_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle();
    n_checks++;
    if (res_valid !== 1'b1 || result !== 32'd12 || zero !== 1'b0 || res_wr !== 5'd3) begin
      n_fail++; $display("[TB] FAIL add_regs got v=%0b r=%h z=%0b wr=%0d want v=1 r=c z=0 wr=3",
                         res_valid, result, zero, res_wr);
    end
    dbg_addr = 5'd3; #1;
    n_checks++;
    if (dbg_data !== 32'd12) begin n_fail++; $display("[TB] FAIL reg3 got %h want c", dbg_data); end
  endtask

  task automatic test_forwarding();
    issue(C_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(C_SUB, 5'd1, 5'd1, 5'd4, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (result !== 32'hFFFF_FFFF || res_wr !== 5'd1) begin
      n_fail++; $display("[TB] FAIL fwd_load got r=%h wr=%0d want ffffffff wr=1", result, res_wr);
    end
    issue(C_SLT, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1 || res_wr !== 5'd4) begin
      n_fail++; $display("[TB] FAIL fwd_sub got r=%h z=%0b wr=%0d want 0 z=1 wr=4", result, zero, res_wr);
    end
    issue(C_SLTU, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0);
    n_checks++;
    if (result !== 32'd1 || zero !== 1'b0) begin
      n_fail++; $display("[TB] FAIL slt got r=%h z=%0b want 1 z=0", result, zero);
    end
    idle();
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1 || res_wr !== 5'd6) begin
      n_fail++; $display("[TB] FAIL sltu got r=%h z=%0b wr=%0d want 0 z=1 wr=6", result, zero, res_wr);
    end
    dbg_addr = 5'd5; #1;
    n_checks++;
    if (dbg_data !== 32'd1) begin n_fail++; $display("[TB] FAIL reg5 got %h want 1", dbg_data); end
    // Immediate-operand SLT forwarding on rr1 only: x7 = 3, then x7 < 4.
    issue(C_ADD, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'd3);
    issue(C_SLT, 5'd7, 5'd0, 5'd8, 1'b1, 1'b1, 32'd4);
    idle();
    n_checks++;
    if (result !== 32'd1 || res_wr !== 5'd8) begin
      n_fail++; $display("[TB] FAIL fwd_imm_slt got r=%h wr=%0d want 1 wr=8", result, res_wr);
    end
  endtask

  task automatic test_x0_zero();
    issue(C_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9);
    issue(C_ADD, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'd0);
    n_checks++;
    if (result !== 32'd9 || res_wr !== 5'd0) begin
      n_fail++; $display("[TB] FAIL x0_wb got r=%h wr=%0d want 9 wr=0", result, res_wr);
    end
    idle();
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      n_fail++; $display("[TB] FAIL x0_nofwd got r=%h z=%0b want 0 z=1", result, zero);
    end
    dbg_addr = 5'd0; #1;
    n_checks++;
    if (dbg_data !== 32'd0) begin n_fail++; $display("[TB] FAIL x0_dbg got %h want 0", dbg_data); end
  endtask

  task automatic test_shifts_logic();
    logic [3:0]  ctls [6] = '{C_AND, C_OR, C_XOR, C_NOR, C_SLL, C_SRL};
    logic [31:0] imms [6] = '{32'hF000_000F, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'd31};
    logic [31:0] exps [6] = '{32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                              32'h0, 32'h1};
    issue(C_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'h8000_0000);
    issue(C_ADD, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'h55);
    issue(C_SRA, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 32'd35);
    issue(C_SRL, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 32'd35);
    n_checks++;
    if (result !== 32'hF000_0000 || res_wr !== 5'd8) begin
      n_fail++; $display("[TB] FAIL sra got r=%h wr=%0d want f0000000 wr=8", result, res_wr);
    end
    issue(C_BAD, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 32'd3);
    n_checks++;
    if (result !== 32'h1000_0000 || res_wr !== 5'd9) begin
      n_fail++; $display("[TB] FAIL srl got r=%h wr=%0d want 10000000 wr=9", result, res_wr);
    end
    idle();
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1 || res_wr !== 5'd10) begin
      n_fail++; $display("[TB] FAIL bad_ctl got r=%h z=%0b wr=%0d want 0 z=1 wr=10", result, zero, res_wr);
    end
    dbg_addr = 5'd10; #1;
    n_checks++;
    if (dbg_data !== 32'd0) begin n_fail++; $display("[TB] FAIL bad_ctl_reg10 got %h want 0", dbg_data); end
    for (int i = 0; i < 6; i++) begin
      issue(ctls[i], 5'd1, 5'd0, 5'd20, 1'b1, 1'b1, imms[i]);
      idle();
      n_checks++;
      if (result !== exps[i] || zero !== (exps[i] == 32'd0)) begin
        n_fail++; $display("[TB] FAIL logic_op[%0d] got r=%h z=%0b want %h", i, result, zero, exps[i]);
      end
    end
  endtask

  task automatic test_hold_reset();
    issue(C_ADD, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'h77);
    issue(C_ADD, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 32'h123);
    hold = 1'b1;
    set_op(C_ADD, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 32'h999);
    dbg_addr = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || result !== 32'h77 || res_wr !== 5'd11 || dbg_data !== 32'd0) begin
        n_fail++; $display("[TB] FAIL hold_frozen[%0d] got v=%0b r=%h wr=%0d reg6=%h want v=1 r=77 wr=11 reg6=0",
                           i, res_valid, result, res_wr, dbg_data);
      end
    end
    hold = 1'b0;
    idle();
    n_checks++;
    if (res_valid !== 1'b1 || result !== 32'h123 || res_wr !== 5'd6 || dbg_data !== 32'h123) begin
      n_fail++; $display("[TB] FAIL hold_resume got v=%0b r=%h wr=%0d reg6=%h want v=1 r=123 wr=6 reg6=123",
                         res_valid, result, res_wr, dbg_data);
    end
    idle();
    dbg_addr = 5'd12; #1;
    n_checks++;
    if (res_valid !== 1'b0 || dbg_data !== 32'd0) begin
      n_fail++; $display("[TB] FAIL hold_dropped_issue got v=%0b reg12=%h want v=0 reg12=0", res_valid, dbg_data);
    end
    issue(C_ADD, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 32'h42);
    rst = 1'b1; hold = 1'b1; op_valid = 1'b0; rw = 1'b0;
    tick();
    rst = 1'b0; hold = 1'b0;
    tick();
    dbg_addr = 5'd13; #1;
    n_checks++;
    if (res_valid !== 1'b0 || dbg_data !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_midop got v=%0b reg13=%h want v=0 reg13=0", res_valid, dbg_data);
    end
    dbg_addr = 5'd6; #1;
    n_checks++;
    if (dbg_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_clears_reg6 got %h want 0", dbg_data); end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; hold = 1'b0; rr1 = '0; rr2 = '0; wr = '0;
    rw = 1'b0; ctl = '0; use_imm = 1'b0; imm = '0; dbg_addr = '0;
    $display("[TB] starting alu_regfile_pipe bench");
    test_reset();
    test_load_add();
    test_forwarding();
    test_x0_zero();
    test_shifts_logic();
    test_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
